// File: rtl/adc_capture_serializer.sv
// Captures DEPTH 128-bit ADC words per shot, then replays them as OUT_W-bit AXIS beats.
// Define CAPTURE_TLAST_EN to add m_axis_tlast marking the final beat of a shot.
module adc_capture_serializer #(
   parameter int DEPTH = 64,
   parameter int OUT_W = 32
) (
   input  logic             pl_clk,
   input  logic             rst,
   input  logic             arm,
   input  logic             trigger,
   input  logic [127:0]     s_axis_tdata,
   input  logic             s_axis_tvalid,
   output logic             s_axis_tready,
   output logic [OUT_W-1:0] m_axis_tdata,
   output logic             m_axis_tvalid,
   input  logic             m_axis_tready,
`ifdef CAPTURE_TLAST_EN
   output logic             m_axis_tlast,
`endif
   output logic             busy,
   output logic             done
);

   localparam int B     = 128 / OUT_W;
   localparam int PTR_W = $clog2(DEPTH);
   localparam int BW    = (B > 1) ? $clog2(B) : 1;

   typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DRAIN} state_t;

   state_t           state;
   state_t           state_nx;
   logic [127:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [BW-1:0]    beat_cnt;
   logic             loaded_all;
   logic             wr_en;
   logic             wr_last;
   logic             ld_en;
   logic             fin;
   logic             beat_last_slice;
   logic             beat_last_word;
   logic [127:0]     word_rd;
   logic [OUT_W-1:0] beat_data;
   logic [OUT_W-1:0] data_p1;
   logic             vld_p1;
   logic             last_p1;

   assign s_axis_tready   = 1'b1;
   assign wr_en           = (state == CAPTURE) && s_axis_tvalid;
   assign wr_last         = wr_en && (wr_ptr == PTR_W'(DEPTH - 1));
   assign beat_last_slice = (beat_cnt == BW'(B - 1));
   assign beat_last_word  = (rd_ptr == PTR_W'(DEPTH - 1));
   // A new beat may enter the output register only when it is empty or being consumed.
   assign ld_en           = (state == DRAIN) && !loaded_all && (!vld_p1 || m_axis_tready);
   assign fin             = (state == DRAIN) && vld_p1 && m_axis_tready && last_p1;
   assign word_rd         = mem[rd_ptr];
   assign beat_data       = OUT_W'(word_rd >> (int'(beat_cnt) * OUT_W));

   always_ff @(posedge pl_clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      case (state)
         IDLE: begin
            if (arm) state_nx = ARMED;
         end
         ARMED: begin
            busy = 1'b1;
            if (trigger) state_nx = CAPTURE;
         end
         CAPTURE: begin
            busy = 1'b1;
            if (wr_last) state_nx = DRAIN;
         end
         DRAIN: begin
            busy = 1'b1;
            if (fin) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // capture stage
   always_ff @(posedge pl_clk or negedge rst) begin
      if (!rst)                  wr_ptr <= '0;
      else if (state != CAPTURE) wr_ptr <= '0;
      else if (wr_en)            wr_ptr <= wr_ptr + PTR_W'(1);
   end

   always_ff @(posedge pl_clk) begin
      if (wr_en) mem[wr_ptr] <= s_axis_tdata;
   end

   // drain read-address stage
   always_ff @(posedge pl_clk or negedge rst) begin
      if (!rst) begin
         rd_ptr     <= '0;
         beat_cnt   <= '0;
         loaded_all <= 1'b0;
      end else if (state != DRAIN) begin
         rd_ptr     <= '0;
         beat_cnt   <= '0;
         loaded_all <= 1'b0;
      end else if (ld_en) begin
         if (beat_last_slice) begin
            beat_cnt <= '0;
            rd_ptr   <= rd_ptr + PTR_W'(1);
            if (beat_last_word) loaded_all <= 1'b1;
         end else begin
            beat_cnt <= beat_cnt + BW'(1);
         end
      end
   end

   // output register stage
   always_ff @(posedge pl_clk or negedge rst) begin
      if (!rst) begin
         vld_p1  <= 1'b0;
         data_p1 <= '0;
         last_p1 <= 1'b0;
      end else if (state != DRAIN) begin
         vld_p1  <= 1'b0;
         last_p1 <= 1'b0;
      end else if (ld_en) begin
         vld_p1  <= 1'b1;
         data_p1 <= beat_data;
         last_p1 <= beat_last_slice && beat_last_word;
      end else if (m_axis_tready) begin
         vld_p1  <= 1'b0;
         last_p1 <= 1'b0;
      end
   end

   always_ff @(posedge pl_clk or negedge rst) begin
      if (!rst) done <= 1'b0;
      else      done <= fin;
   end

   assign m_axis_tdata  = data_p1;
   assign m_axis_tvalid = vld_p1;
`ifdef CAPTURE_TLAST_EN
   assign m_axis_tlast  = last_p1;
`endif

endmodule

// File: tb/tb_adc_capture_serializer.sv
// Directed bench for adc_capture_serializer at DEPTH=4, OUT_W=32 (16 beats per shot).
module tb_adc_capture_serializer;

   logic         pl_clk;
   logic         rst;
   logic         arm;
   logic         trigger;
   logic [127:0] s_axis_tdata;
   logic         s_axis_tvalid;
   logic         s_axis_tready;
   logic [31:0]  m_axis_tdata;
   logic         m_axis_tvalid;
   logic         m_axis_tready;
`ifdef CAPTURE_TLAST_EN
   logic         m_axis_tlast;
`endif
   logic         busy;
   logic         done;

   int checks = 0;
   int errors = 0;

   adc_capture_serializer #(.DEPTH(4), .OUT_W(32)) dut (
      .pl_clk        (pl_clk),
      .rst           (rst),
      .arm           (arm),
      .trigger       (trigger),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
`ifdef CAPTURE_TLAST_EN
      .m_axis_tlast  (m_axis_tlast),
`endif
      .busy          (busy),
      .done          (done)
   );

   initial pl_clk = 1'b0;
   always #5 pl_clk = ~pl_clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Beat k of a shot holds bytes 4k..4k+3 (plus a per-shot offset), low byte first.
   function automatic logic [31:0] beat_val(input logic [7:0] off, input int k);
      logic [7:0] b;
      b = 8'(4 * k) + off;
      return {b + 8'd3, b + 8'd2, b + 8'd1, b};
   endfunction

   function automatic logic [127:0] word_val(input logic [7:0] off, input int w);
      return {beat_val(off, 4*w+3), beat_val(off, 4*w+2), beat_val(off, 4*w+1), beat_val(off, 4*w)};
   endfunction

   task automatic do_arm();
      arm = 1'b1;
      @(negedge pl_clk);
      arm = 1'b0;
      chk("armed_busy", busy, 1);
   endtask

   // Trigger cycle carries a junk word that must not be stored.
   task automatic do_trig();
      trigger       = 1'b1;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = {4{32'hBAD0BAD0}};
      @(negedge pl_clk);
      trigger       = 1'b0;
      s_axis_tvalid = 1'b0;
   endtask

   task automatic send_words(input logic [7:0] off, input bit gap);
      for (int w = 0; w < 4; w++) begin
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = word_val(off, w);
         @(negedge pl_clk);
         if (gap && w < 3) begin
            s_axis_tvalid = 1'b0;
            s_axis_tdata  = {4{32'hDEADBEEF}};
            @(negedge pl_clk);
         end
      end
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = '0;
   endtask

   // Entered at the negedge of the first DRAIN cycle; returns after stop_after handshakes.
   task automatic drain(input logic [7:0] off, input bit bp, input bit noise,
                        input int stop_after, output int got);
      int          cyc;
      int          first_cyc;
      int          last_cyc;
      bit          stalled;
      bit          rdy;
      logic [31:0] held;
      got       = 0;
      cyc       = 0;
      first_cyc = -1;
      last_cyc  = -1;
      stalled   = 1'b0;
      held      = '0;
      while (got < stop_after && cyc < 300) begin
         if (stalled) begin
            chk("hold_vld", m_axis_tvalid, 1);
            chk("hold_data", m_axis_tdata, held);
         end
         chk("no_early_done", done, 0);
         if (noise) begin
            arm     = (cyc >= 1 && cyc < 5);
            trigger = arm;
         end
         rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         m_axis_tready = rdy;
         if (m_axis_tvalid) begin
            if (first_cyc < 0) first_cyc = cyc;
            if (rdy) begin
               chk($sformatf("beat%0d", got), m_axis_tdata, beat_val(off, got));
`ifdef CAPTURE_TLAST_EN
               chk($sformatf("tlast%0d", got), m_axis_tlast, got == 15);
`endif
               got++;
               last_cyc = cyc;
               stalled  = 1'b0;
            end else begin
               stalled = 1'b1;
               held    = m_axis_tdata;
            end
         end else begin
            stalled = 1'b0;
         end
         @(negedge pl_clk);
         cyc++;
      end
      arm     = 1'b0;
      trigger = 1'b0;
      chk("beats_seen", got, stop_after);
      chk("first_beat_latency_ok", first_cyc >= 0 && first_cyc <= 2, 1);
      if (!bp && stop_after == 16) chk("gapless_span", last_cyc - first_cyc, 15);
   endtask

   task automatic finish_checks();
      chk("end_vld", m_axis_tvalid, 0);
      chk("end_done", done, 1);
      chk("end_busy", busy, 0);
      @(negedge pl_clk);
      chk("done_one_cycle", done, 0);
      chk("idle_busy", busy, 0);
   endtask

   task automatic shot(input logic [7:0] off, input bit gap, input bit bp, input bit noise);
      int got;
      do_arm();
      do_trig();
      send_words(off, gap);
      drain(off, bp, noise, 16, got);
      finish_checks();
   endtask

   initial begin
      int got;
      rst           = 1'b0;
      arm           = 1'b0;
      trigger       = 1'b0;
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = '0;
      m_axis_tready = 1'b0;
      repeat (3) @(negedge pl_clk);
      chk("rst_vld", m_axis_tvalid, 0);
      chk("rst_data", m_axis_tdata, 0);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_tready", s_axis_tready, 1);
`ifdef CAPTURE_TLAST_EN
      chk("rst_tlast", m_axis_tlast, 0);
`endif
      rst = 1'b1;
      repeat (2) @(negedge pl_clk);
      chk("idle_after_rst", busy, 0);

      // basic, gapped input, random back-pressure
      shot(8'h00, 1'b0, 1'b0, 1'b0);
      shot(8'h10, 1'b1, 1'b0, 1'b0);
      shot(8'h20, 1'b0, 1'b1, 1'b0);

      // trigger without arm
      trigger       = 1'b1;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = {4{32'h11111111}};
      for (int i = 0; i < 6; i++) begin
         @(negedge pl_clk);
         chk("noarm_busy", busy, 0);
         chk("noarm_vld", m_axis_tvalid, 0);
      end
      trigger       = 1'b0;
      s_axis_tvalid = 1'b0;

      // arm and trigger together: arms only
      arm     = 1'b1;
      trigger = 1'b1;
      @(negedge pl_clk);
      arm     = 1'b0;
      trigger = 1'b0;
      chk("armtrig_busy", busy, 1);
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = {4{32'h22222222}};
      for (int i = 0; i < 6; i++) begin
         @(negedge pl_clk);
         chk("armtrig_no_capture", m_axis_tvalid, 0);
         chk("armtrig_still_armed", busy, 1);
      end
      s_axis_tvalid = 1'b0;
      do_trig();
      send_words(8'h40, 1'b0);
      drain(8'h40, 1'b0, 1'b0, 16, got);
      finish_checks();

      // arm and trigger toggled during DRAIN
      shot(8'h60, 1'b0, 1'b0, 1'b1);
      repeat (3) begin
         @(negedge pl_clk);
         chk("no_extra_shot", busy, 0);
      end

      // reset after beat 6 of a drain
      do_arm();
      do_trig();
      send_words(8'h80, 1'b0);
      drain(8'h80, 1'b0, 1'b0, 7, got);
      rst = 1'b0;
      #1;
      chk("abort_vld", m_axis_tvalid, 0);
      chk("abort_busy", busy, 0);
      chk("abort_data", m_axis_tdata, 0);
      @(negedge pl_clk);
      rst = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge pl_clk);
         chk("abort_no_done", done, 0);
         chk("abort_idle", busy, 0);
         chk("abort_no_vld", m_axis_tvalid, 0);
      end
      shot(8'hA0, 1'b0, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/adc_capture_serializer.md
ADC_CAPTURE_SERIALIZER -- requirements
Module: adc_capture_serializer

Interface
REQ-001 SHALL have parameter DEPTH, default 64, number of 128-bit ADC words captured per shot (power of 2, >= 2).
REQ-002 SHALL have parameter OUT_W, default 32, PS-side AXIS data width (divisor of 128; beats per word B = 128/OUT_W).
REQ-003 SHALL have port pl_clk, input, 1, sole clock; all logic rising-edge.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous active-low.
REQ-005 SHALL have port arm, input, 1, level; requests arming from IDLE.
REQ-006 SHALL have port trigger, input, 1, level; starts capture when ARMED.
REQ-007 SHALL have ports s_axis_tdata (input, 128), s_axis_tvalid (input, 1) and s_axis_tready (output, 1), the ADC AXIS slave.
REQ-008 SHALL have ports m_axis_tdata (output, OUT_W), m_axis_tvalid (output, 1) and m_axis_tready (input, 1), the AXIS master toward the PS readout mux.
REQ-009 SHALL have port m_axis_tlast, output, 1, final-beat marker; present only under CAPTURE_TLAST_EN.
REQ-010 SHALL have port busy, output, 1, high in ARMED, CAPTURE and DRAIN.
REQ-011 SHALL have port done, output, 1, one-cycle pulse at drain completion.

Function
REQ-012 SHALL implement FSM states IDLE, ARMED, CAPTURE, DRAIN.
REQ-013 IDLE->ARMED when arm=1; trigger in IDLE ignored, including arm and trigger high in the same cycle.
REQ-014 ARMED->CAPTURE on the first cycle trigger=1; words present in that trigger cycle are not stored.
REQ-015 In CAPTURE, each cycle with s_axis_tvalid=1 SHALL store s_axis_tdata at the write pointer and increment it; cycles with tvalid=0 store nothing.
REQ-016 CAPTURE->DRAIN on the cycle the word at index DEPTH-1 is stored; the write pointer wraps to 0.
REQ-017 s_axis_tready SHALL be 1 in every state, since the ADC is never back-pressured; words outside CAPTURE are discarded.
REQ-018 In DRAIN, each stored word SHALL be emitted as B beats, least-significant OUT_W slice first, words in capture order; total DEPTH*B beats.
REQ-019 m_axis_tvalid SHALL assert no later than 2 cycles after DRAIN entry.
REQ-020 Once m_axis_tvalid is asserted, m_axis_tvalid and m_axis_tdata SHALL hold stable until m_axis_tvalid and m_axis_tready are both high.
REQ-021 Beats SHALL be sustainable at one per cycle while m_axis_tready=1, with no bubbles between words.
REQ-022 After the handshake of beat DEPTH*B-1: m_axis_tvalid=0 next cycle, done=1 for exactly that cycle, state->IDLE.
REQ-023 arm and trigger SHALL be ignored in CAPTURE and DRAIN; re-arming requires return to IDLE.

Reset
REQ-024 While rst=0: state IDLE, pointers and beat counter 0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, done=0, busy=0; s_axis_tready=1.
REQ-025 Reset asserted mid-CAPTURE or mid-DRAIN SHALL abort immediately, discard partial data and emit no done; buffer contents need not be cleared.
REQ-026 On rst deassertion the block SHALL remain in IDLE until arm is seen.

Configuration
REQ-027 Macro CAPTURE_TLAST_EN defined: m_axis_tlast exists and is 1 exactly on beat DEPTH*B-1, else 0, held stable with the data.
REQ-028 Macro CAPTURE_TLAST_EN undefined: m_axis_tlast port and its logic are absent; all other behaviour is identical.

Verification (DEPTH=4, OUT_W=32, B=4)
REQ-029 Basic shot: arm pulse, trigger pulse, then 4 consecutive valid words 0x..03020100 patterns, m_axis_tready=1 -> 16 beats in order (word0 bits[31:0] first), 16 consecutive cycles, done pulse once, busy low after.
REQ-030 Gapped input: tvalid toggling 1/0 during CAPTURE -> exactly 4 words stored, no duplicates or skips.
REQ-031 Back-pressure: m_axis_tready random 50% -> identical 16-beat sequence; tdata/tvalid stable during every stall.
REQ-032 Ignored controls: trigger with no prior arm, arm+trigger in the same cycle, arm during DRAIN -> no capture started, no extra shot.
REQ-033 Reset mid-DRAIN after beat 6: rst low 1 cycle -> tvalid=0, done never pulses, busy=0; a following full shot is correct.
REQ-034 With CAPTURE_TLAST_EN: tlast high only on beat 15; without the macro, the build succeeds with no tlast port.
